// File: rtl/multi_channel_data_selector.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_data_selector
// Purpose  : Registered NUM_CH:1 selector of WIDTH-bit channels with a manual
//            (SEL-driven) mode and an auto-scan mode that dwells DWELL clocks
//            per channel; outputs carry a channel tag, VALID and STEP strobe.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_data_selector #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int DWELL  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_CH*WIDTH-1:0] i_d,
    input  logic [SEL_W-1:0]        i_sel,
    input  logic                    i_mode,
    input  logic                    i_en,
    output logic [WIDTH-1:0]        o_q,
    output logic [SEL_W-1:0]        o_ch,
    output logic                    o_valid,
    output logic                    o_step
);

    localparam int              CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] C_CH_LAST  = SEL_W'(NUM_CH - 1);
    // One extra bit so NUM_CH == 2**SEL_W does not truncate to zero.
    localparam logic [SEL_W:0]   C_NUM_CH   = (SEL_W + 1)'(NUM_CH);

    typedef enum logic [0:0] {
        S_MANUAL = 1'b0,
        S_SCAN   = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [SEL_W-1:0]   r_ch;
    logic [WIDTH-1:0]   r_q;
    logic               r_valid;
    logic               r_step;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]   w_ch_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   w_q_sel;
    logic               w_valid_nxt;
    logic               w_step_nxt;
    logic               w_sel_ok;
    logic [WIDTH-1:0]   w_chan [NUM_CH];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_chan[gi] = i_d[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_sel_ok = ({1'b0, i_sel} < C_NUM_CH);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_MANUAL;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_q     <= '0;
            r_valid <= 1'b0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ch    <= w_ch_nxt;
            r_q     <= w_q_nxt;
            r_valid <= w_valid_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Next-state logic; with EN low everything holds and only the strobes drop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ch_nxt    = r_ch;
        w_valid_nxt = 1'b0;
        w_step_nxt  = 1'b0;
        if (i_en) begin
            w_valid_nxt = 1'b1;
            if (!i_mode) begin
                // Leaving scan is handled as an ordinary manual edge.
                w_state_nxt = S_MANUAL;
                w_cnt_nxt   = '0;
                if (w_sel_ok) begin
                    w_ch_nxt = i_sel;
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end else if (r_state == S_MANUAL) begin
                w_state_nxt = S_SCAN;
                w_cnt_nxt   = '0;
            end else if (r_cnt == C_CNT_LAST) begin
                w_cnt_nxt  = '0;
                w_ch_nxt   = (r_ch == C_CH_LAST) ? '0 : r_ch + SEL_W'(1);
                w_step_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Data follows the channel being loaded, so Q and CH never disagree.
    always_comb begin
        w_q_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_nxt == SEL_W'(k)) begin
                w_q_sel = w_chan[k];
            end
        end
        w_q_nxt = i_en ? w_q_sel : r_q;
    end

    assign o_q     = r_q;
    assign o_ch    = r_ch;
    assign o_valid = r_valid;
    assign o_step  = r_step;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_data_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_data_selector
// Purpose  : Directed bench for three selector configurations, checked every
//            cycle against a behavioural model plus hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_data_selector;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] d4;   // 4 channels, DWELL=4
    logic [23:0] d3;   // 3 channels, DWELL=16
    logic [15:0] dc;   // 2 channels, DWELL=1

    logic [7:0] q4, q3, qc;
    logic [1:0] ch4, ch3;
    logic [0:0] chc;
    logic       v4, v3, vc, s4, s3, sc;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    multi_channel_data_selector #(.WIDTH(8), .NUM_CH(4), .SEL_W(2), .DWELL(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_d(d4), .i_sel(sel), .i_mode(mode), .i_en(en),
        .o_q(q4), .o_ch(ch4), .o_valid(v4), .o_step(s4)
    );
    multi_channel_data_selector #(.WIDTH(8), .NUM_CH(3), .SEL_W(2), .DWELL(16)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_d(d3), .i_sel(sel), .i_mode(mode), .i_en(en),
        .o_q(q3), .o_ch(ch3), .o_valid(v3), .o_step(s3)
    );
    multi_channel_data_selector #(.WIDTH(8), .NUM_CH(2), .SEL_W(1), .DWELL(1)) u_dutc (
        .i_clk(clk), .i_rst(rst), .i_d(dc), .i_sel(sel[0]), .i_mode(mode), .i_en(en),
        .o_q(qc), .o_ch(chc), .o_valid(vc), .o_step(sc)
    );

    // ---------------- behavioural model ----------------
    bit       m_scan  [3];
    int       m_cnt   [3];
    int       m_ch    [3];
    bit [7:0] m_q     [3];
    bit       m_valid [3];
    bit       m_step  [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_scan[k] = 0; m_cnt[k] = 0; m_ch[k] = 0;
            m_q[k] = 8'h00; m_valid[k] = 0; m_step[k] = 0;
        end
    endtask

    task automatic model_edge(input int k, input int nch, input int dw,
                              input int s, input logic [31:0] d);
        if (!en) begin
            m_valid[k] = 0;
            m_step[k]  = 0;
            return;
        end
        m_valid[k] = 1;
        m_step[k]  = 0;
        if (!mode) begin
            m_scan[k] = 0;
            m_cnt[k]  = 0;
            if (s < nch) m_ch[k] = s;
            else         m_valid[k] = 0;
        end else if (!m_scan[k]) begin
            m_scan[k] = 1;
            m_cnt[k]  = 0;
        end else if (m_cnt[k] == dw - 1) begin
            m_cnt[k]  = 0;
            m_ch[k]   = (m_ch[k] + 1) % nch;
            m_step[k] = 1;
        end else begin
            m_cnt[k]++;
        end
        m_q[k] = 8'(d >> (m_ch[k] * 8));
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            model_edge(0, 4, 4,  int'(sel),    d4);
            model_edge(1, 3, 16, int'(sel),    {8'h00, d3});
            model_edge(2, 2, 1,  int'(sel[0]), {16'h0000, dc});
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("m4_q", int'(q4), int'(m_q[0]));   check("m4_ch", int'(ch4), m_ch[0]);
            check("m4_v", int'(v4), int'(m_valid[0])); check("m4_s", int'(s4), int'(m_step[0]));
            check("m3_q", int'(q3), int'(m_q[1]));   check("m3_ch", int'(ch3), m_ch[1]);
            check("m3_v", int'(v3), int'(m_valid[1])); check("m3_s", int'(s3), int'(m_step[1]));
            check("mc_q", int'(qc), int'(m_q[2]));   check("mc_ch", int'(chc), m_ch[2]);
            check("mc_v", int'(vc), int'(m_valid[2])); check("mc_s", int'(sc), int'(m_step[2]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_q4"}, int'(q4), 0);  check({tag, "_ch4"}, int'(ch4), 0);
        check({tag, "_v4"}, int'(v4), 0);  check({tag, "_s4"}, int'(s4), 0);
        check({tag, "_q3"}, int'(q3), 0);  check({tag, "_ch3"}, int'(ch3), 0);
        check({tag, "_v3"}, int'(v3), 0);  check({tag, "_s3"}, int'(s3), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] held;
        int         exp_ch;
        rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 2'd0;
        d4 = '0; d3 = '0; dc = '0;
        tick();
        chk_on = 1'b1;
        tick();
        check_zero("reset");
        rst = 1'b0;

        // Manual selection
        d4 = 32'h44332211; d3 = 24'hCCBBAA; dc = 16'hF00F;
        en = 1'b1; sel = 2'd2;
        tick();
        check("man_q4", int'(q4), 8'h33); check("man_ch4", int'(ch4), 2);
        check("man_v4", int'(v4), 1);     check("man_q3", int'(q3), 8'hCC);
        sel = 2'd0;
        tick();
        check("man0_q4", int'(q4), 8'h11); check("man0_ch4", int'(ch4), 0);

        // Asynchronous reset between edges
        sel = 2'd2;
        tick();
        rst = 1'b1;
        #1;
        check_zero("async");
        #1;
        rst = 1'b0;

        // Out-of-range select on the 3-channel instance
        sel = 2'd1;
        tick();
        check("oor_pre_ch3", int'(ch3), 1); check("oor_pre_q3", int'(q3), 8'hBB);
        d3 = 24'hCCDDAA; sel = 2'd3;
        tick();
        check("oor_ch3", int'(ch3), 1); check("oor_q3", int'(q3), 8'hDD);
        check("oor_v3", int'(v3), 0);   check("oor_ch4", int'(ch4), 3);
        sel = 2'd0;
        tick();
        check("oor0_ch3", int'(ch3), 0); check("oor0_v3", int'(v3), 1);

        // Scan wrap: DWELL=4 holds each channel 4 edges (entry edge included)
        mode = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            d4 = d4 + 32'h01010101;
            tick();
            exp_ch = ((e - 1) / 4) % 4;
            check($sformatf("scan_ch4_e%0d", e), int'(ch4), exp_ch);
            check($sformatf("scan_s4_e%0d", e), int'(s4), (e > 1 && (e - 1) % 4 == 0) ? 1 : 0);
            check($sformatf("scan_q4_e%0d", e), int'(q4), int'(d4[exp_ch*8 +: 8]));
            check($sformatf("scan_chc_e%0d", e), int'(chc), (e - 1) % 2);
            check($sformatf("scan_sc_e%0d", e), int'(sc), (e > 1) ? 1 : 0);
        end

        // Freeze mid-dwell: 3-channel instance is at CH=1 with cnt=0 here
        repeat (9) tick();
        check("frz_pre_ch3", int'(ch3), 1);
        held = q3;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d3 = d3 ^ 24'h5A5A5A;
            mode = i[0];
            tick();
            check("frz_ch3", int'(ch3), 1);   check("frz_q3", int'(q3), int'(held));
            check("frz_v3", int'(v3), 0);     check("frz_s3", int'(s3), 0);
        end
        mode = 1'b1; en = 1'b1;
        // cnt resumes at 9: six more increments reach DWELL-1, the 7th edge advances
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("res_ch3_%0d", i), int'(ch3), (i == 7) ? 2 : 1);
            check($sformatf("res_s3_%0d", i), int'(s3), (i == 7) ? 1 : 0);
        end

        // Mode switch out of scan at CH=3
        for (int i = 0; i < 20 && m_ch[0] != 3; i++) tick();
        if (m_ch[0] != 3) timeout("wait_ch4_3");
        check("sw_pre_ch4", int'(ch4), 3);
        mode = 1'b0; sel = 2'd1;
        tick();
        check("sw_ch4", int'(ch4), 1); check("sw_s4", int'(s4), 0);
        check("sw_v4", int'(v4), 1);   check("sw_q4", int'(q4), int'(d4[15:8]));
        mode = 1'b1;
        tick();
        check("re_ch4", int'(ch4), 1); check("re_s4", int'(s4), 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("re_ch4_%0d", i), int'(ch4), (i == 4) ? 2 : 1);
            check($sformatf("re_s4_%0d", i), int'(s4), (i == 4) ? 1 : 0);
        end

        // Reset mid-scan on the 3-channel instance at CH=2, cnt=7
        for (int i = 0; i < 60 && !(m_ch[1] == 2 && m_cnt[1] == 7); i++) tick();
        if (!(m_ch[1] == 2 && m_cnt[1] == 7)) timeout("wait_ch3_2_cnt7");
        check("mid_pre_ch3", int'(ch3), 2);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        #1;
        rst = 1'b0;
        for (int e = 1; e <= 17; e++) begin
            tick();
            check($sformatf("post_ch3_e%0d", e), int'(ch3), (e == 17) ? 1 : 0);
            check($sformatf("post_s3_e%0d", e), int'(s3), (e == 17) ? 1 : 0);
        end

        tick();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_data_selector.md
Name: multi_channel_data_selector

Overview:
- Parametrised, registered N:1 data selector. It is the next generation of the team's single-bit 2:1 selector.
- It selects one WIDTH-bit channel out of NUM_CH channels.
- Two modes:
  - Manual: SEL chooses the channel.
  - Auto-scan: the block steps through the channels itself, holding each one for DWELL clocks.
- Output is registered with a channel tag, VALID and a STEP strobe. It sits between the input channel bank and the downstream display/capture logic.

Parameters:
- WIDTH, 8, bits per channel.
- NUM_CH, 4, number of input channels. Must be ≥ 2.
- SEL_W, 2, width of the channel index. Must be ≥ clog2(NUM_CH).
- DWELL, 16, clocks spent on each channel in scan mode. Must be ≥ 1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- D  in  NUM_CH*WIDTH  packed channel data; channel k is D[k*WIDTH +: WIDTH].
- SEL  in  SEL_W  channel select; used only in manual mode.
- MODE  in  1  0 = manual, 1 = auto-scan; sampled every clock.
- EN  in  1  1 = run, 0 = freeze all state.
- Q  out  WIDTH  registered selected data.
- CH  out  SEL_W  registered index of the channel currently driving Q.
- VALID  out  1  Q/CH hold a legitimate fresh selection this cycle.
- STEP  out  1  one-clock pulse on the edge where scan mode advances CH.

Behaviour:
- Reset (RST=1, asynchronous, takes effect with no clock):
  - Q=0, CH=0, VALID=0, STEP=0.
  - Dwell counter cnt=0; state=MANUAL.
  - On RST release, the first active edge behaves as a normal operating edge.
  - RST asserted mid-scan or mid-dwell discards all progress; scan restarts at channel 0.
- State machine (2 states, MANUAL and SCAN), updated only when EN=1:
  - MANUAL -> SCAN when MODE=1: CH keeps its current value, cnt cleared to 0, STEP=0 on that edge.
  - SCAN -> MANUAL when MODE=0: cnt cleared; that same edge is processed as a manual edge using SEL.
- Latency: one clock. Q and CH are always consistent: after every enabled edge, Q = D[CH] as sampled at that edge, where CH is the value being loaded on that edge.
- Manual edge (EN=1):
  - SEL < NUM_CH: CH<=SEL, Q<=D[SEL], VALID<=1.
  - SEL ≥ NUM_CH (out of range): CH holds, Q<=D[CH held], VALID<=0. No X and no wrap of SEL.
  - STEP=0 always in manual mode.
- Scan edge (EN=1):
  - cnt<DWELL-1: cnt<=cnt+1, CH holds, Q<=D[CH], VALID<=1, STEP<=0.
  - cnt==DWELL-1: cnt<=0, CH<=(CH==NUM_CH-1)?0:CH+1, Q<=D[new CH], VALID<=1, STEP<=1 for exactly that cycle.
  - DWELL=1: CH advances every clock and STEP stays high continuously.
  - SEL is ignored in scan mode.
- EN=0:
  - Q, CH, cnt and state frozen; MODE changes are ignored.
  - VALID<=0, STEP<=0.
  - On the first edge with EN=1 again, operation resumes from the frozen cnt. The dwell count does not restart.
- Counter width: clog2(DWELL), minimum 1 bit. No overflow is possible.
- D changing mid-dwell is tracked every clock; Q follows the live data of the selected channel.
- Outputs change only on CLK edges or RST. There is no combinational path from inputs to outputs.

Test Plan:
1. Reset and manual selection:
   - RST pulsed asynchronously between edges -> Q=0, CH=0, VALID=0 immediately.
   - Release; D={8'h44,8'h33,8'h22,8'h11}, MODE=0, EN=1, SEL=2 -> next edge Q=8'h33, CH=2, VALID=1.
   - SEL=0 -> Q=8'h11, CH=0.
2. Out-of-range SEL:
   - NUM_CH=3, SEL_W=2, CH=1, SEL=3 -> CH stays 1, Q=D[1], VALID=0.
   - SEL=0 -> CH=0, VALID=1.
3. Scan wrap:
   - MODE=1, DWELL=4, CH starts at 0 -> CH sequence 0,1,2,3,0.
   - Each channel held exactly 4 clocks; STEP high exactly on the 4 advancing edges.
   - Q tracks D[CH] throughout.
4. Freeze mid-dwell:
   - SCAN, DWELL=16, cnt=9.
   - EN=0 for 5 clocks -> Q/CH unchanged, VALID=0, STEP=0.
   - EN=1 -> CH advances after exactly 6 more enabled edges.
5. Mode switch:
   - SCAN at CH=3, then MODE=0 with SEL=1 -> same edge CH=1, STEP=0.
   - MODE=1 again -> scan resumes from CH=1 with a full DWELL.
6. Reset mid-scan:
   - RST asserted while CH=2, cnt=7 -> all outputs reset asynchronously.
   - After release with MODE=1 -> first edge enters SCAN at CH=0, and the first STEP follows DWELL edges later.
